mipi_lane_align_controller: RTL
===============================

# mipi_lane_align_controller

Sequences the per-lane byte aligners of the CSI-2 receiver across each high-speed burst. It holds every lane's aligner in reset through the LP→HS settle period, then releases them together. It tracks each lane's sync-detect, checks inter-lane skew and enforces a hunt timeout. It reports a single aligned/error status to the packet decoder and sits between the D-PHY LP/HS detector and the lane byte aligners.

## Interface
Parameters:
- LANES, 2, number of data lanes (1–4)
- SETTLE_CYCLES, 3, cycles aligner reset is held after HS entry (≥1)
- TIMEOUT_CYCLES, 64, max cycles in HUNT before any lane must sync (≥2)
- SKEW_WINDOW, 4, max cycles between first and last lane sync (≥1)

Ports:
- clk_i  in  1  byte clock, rising-edge
- reset_n_i  in  1  asynchronous, active-low reset
- hs_request_i  in  1  level; high while the PHY is in an HS burst
- lane_sync_i  in  LANES  per-lane sync-pattern-found pulse/level from each aligner
- packet_done_i  in  1  one-cycle pulse from the packet decoder at end of packet
- aligner_reset_o  out  LANES  active-high reset to each byte aligner
- lanes_aligned_o  out  1  high while all lanes are locked
- align_error_o  out  1  one-cycle pulse on alignment failure
- error_count_o  out  8  saturating count of alignment failures

## Operation
- Reset values: state IDLE, aligner_reset_o all 1, lanes_aligned_o 0, align_error_o 0, error_count_o 0, all counters and sticky bits 0.
- IDLE: aligner_reset_o all 1. hs_request_i=1 → RESET with cycle counter cleared.
- RESET: aligner_reset_o all 1. Counts SETTLE_CYCLES cycles, then → HUNT. Sticky sync bits, timeout counter and skew counter are cleared on entry to HUNT.
- HUNT: aligner_reset_o all 0. Sticky bits OR in lane_sync_i each cycle. Timeout counter increments every cycle. Skew counter starts the cycle after the first sticky bit sets and increments while any bit is still clear.
  - All sticky bits set (including this cycle's lane_sync_i) → LOCKED.
  - Skew counter == SKEW_WINDOW with bits missing → ERROR.
  - Timeout counter == TIMEOUT_CYCLES with no bit set → ERROR.
- LOCKED: lanes_aligned_o=1, aligner_reset_o all 0. packet_done_i=1 → IDLE. Further lane_sync_i is ignored.
- ERROR: one cycle. align_error_o=1, aligner_reset_o all 1, error_count_o increments and saturates at 255. Then → WAIT_LP.
- WAIT_LP: aligner_reset_o all 1. hs_request_i=0 → IDLE. A failed burst is never retried within the same burst.
- Priority, highest first:
  1. hs_request_i=0 in RESET/HUNT/LOCKED → IDLE, with no error raised.
  2. Lock beats skew/timeout expiry in the same cycle.
  3. packet_done_i outside LOCKED is ignored.
- Counter widths are $clog2 of the respective parameter +1. No counter wraps; each saturates at its compare value.
- Asynchronous reset mid-burst returns all outputs to their reset values immediately. After reset release, the block waits in IDLE for a fresh hs_request_i level.

## Timing
- All outputs are registered and decoded from the state register.
- hs_request_i rises, sampled at edge 0 → RESET from edge 1 → aligner_reset_o falls after edge 1+SETTLE_CYCLES (HUNT entry).
- lane_sync_i completing the set, sampled at edge N → lanes_aligned_o high from edge N+1.
- packet_done_i or hs_request_i falling, sampled at edge M → lanes_aligned_o low and aligner_reset_o all 1 from edge M+1.
- align_error_o is exactly one cycle wide.
- Minimum burst-to-burst turnaround: one cycle in IDLE.

## Structure
- Package mipi_align_pkg: state enum (IDLE, RESET, HUNT, LOCKED, ERROR, WAIT_LP), MAX_LANES=4, ERR_CNT_W=8.
- Sub-module lane_sync_tracker holds the sticky sync bits, the all/any flags and the skew counter.
- The top level holds the FSM, settle/timeout counters and error counter.

## Test plan
Default parameters (LANES=2, SETTLE=3, TIMEOUT=64, SKEW=4):
- Nominal lock: hs_request_i↑, lane_sync_i=2'b11 on HUNT cycle 5 → aligner_reset_o=00 after 4 edges, lanes_aligned_o=1 next cycle. packet_done_i → returns to IDLE with reset=11.
- Skewed within window: lane0 syncs at HUNT cycle 2, lane1 at cycle 5 → LOCKED, no error.
- Skew violation: lane0 syncs at cycle 2, lane1 never → align_error_o pulse at skew count 4, error_count_o=1, WAIT_LP until hs_request_i↓.
- Timeout: no sync for 64 HUNT cycles → align_error_o pulse, aligner_reset_o=11. A second failure gives error_count_o=2. Force 300 failures → error_count_o=255.
- Abort: hs_request_i↓ during HUNT and again during LOCKED → IDLE next cycle, align_error_o stays 0.
- Async reset: assert reset_n_i in LOCKED between clock edges → lanes_aligned_o=0 and aligner_reset_o=11 without waiting for a clock edge. Release → IDLE.

Source files
------------

// File: rtl/mipi_align_pkg.sv
// Shared types and constants for the CSI-2 lane alignment controller.
package mipi_align_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESET   = 3'd1,
        HUNT    = 3'd2,
        LOCKED  = 3'd3,
        ERROR   = 3'd4,
        WAIT_LP = 3'd5
    } align_state_e;

    localparam int MAX_LANES = 4;
    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/lane_sync_tracker.sv
// Sticky per-lane sync bits and the inter-lane skew counter, active only in HUNT.
module lane_sync_tracker #(
    parameter int LANES       = 2,
    parameter int SKEW_WINDOW = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             hunt_i,
    input  logic [LANES-1:0] lane_sync_i,
    output logic             all_sync_o,
    output logic             any_sync_o,
    output logic             skew_expired_o
);
    localparam int SKEW_W = $clog2(SKEW_WINDOW) + 1;
    localparam logic [SKEW_W-1:0] SKEW_MAX = SKEW_W'(SKEW_WINDOW);

    logic [LANES-1:0]  sticky_q, sticky_d;
    logic [SKEW_W-1:0] skew_q, skew_d;

    // all/any include this cycle's sync so a completing lane locks without delay.
    assign all_sync_o     = &(sticky_q | lane_sync_i);
    assign any_sync_o     = |(sticky_q | lane_sync_i);
    assign skew_expired_o = (skew_q == SKEW_MAX);

    always_comb begin
        sticky_d = '0;
        skew_d   = '0;
        if (hunt_i) begin
            sticky_d = sticky_q | lane_sync_i;
            skew_d   = skew_q;
            if ((|sticky_q) && !(&sticky_q) && (skew_q != SKEW_MAX)) begin
                skew_d = skew_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sticky_q <= '0;
            skew_q   <= '0;
        end else begin
            sticky_q <= sticky_d;
            skew_q   <= skew_d;
        end
    end

endmodule

// File: rtl/mipi_lane_align_controller.sv
// Per-burst sequencer for the lane byte aligners: settle, hunt, lock, error reporting.
module mipi_lane_align_controller
    import mipi_align_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int SETTLE_CYCLES  = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SKEW_WINDOW    = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 hs_request_i,
    input  logic [LANES-1:0]     lane_sync_i,
    input  logic                 packet_done_i,
    output logic [LANES-1:0]     aligner_reset_o,
    output logic                 lanes_aligned_o,
    output logic                 align_error_o,
    output logic [ERR_CNT_W-1:0] error_count_o
);
    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);

    align_state_e         state_q, state_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [TO_W-1:0]      timeout_q, timeout_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [LANES-1:0]     aligner_reset_q, aligner_reset_d;
    logic                 aligned_q, aligned_d;
    logic                 error_q, error_d;
    logic                 all_sync, any_sync, skew_expired;

    lane_sync_tracker #(
        .LANES       (LANES),
        .SKEW_WINDOW (SKEW_WINDOW)
    ) u_tracker (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .hunt_i         (state_q == HUNT),
        .lane_sync_i    (lane_sync_i),
        .all_sync_o     (all_sync),
        .any_sync_o     (any_sync),
        .skew_expired_o (skew_expired)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (hs_request_i) begin
                    state_d  = RESET;
                    settle_d = '0;
                end
            end
            RESET: begin
                if (!hs_request_i) begin
                    state_d = IDLE;
                end else if (settle_q == SET_LAST) begin
                    state_d   = HUNT;
                    timeout_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            HUNT: begin
                // Abort outranks lock, and lock outranks either expiry.
                if (!hs_request_i) begin
                    state_d = IDLE;
                end else if (all_sync) begin
                    state_d = LOCKED;
                end else if (skew_expired) begin
                    state_d = ERROR;
                end else if ((timeout_q == TO_MAX) && !any_sync) begin
                    state_d = ERROR;
                end else if (timeout_q != TO_MAX) begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            LOCKED: begin
                if (!hs_request_i || packet_done_i) begin
                    state_d = IDLE;
                end
            end
            ERROR:   state_d = WAIT_LP;
            WAIT_LP: begin
                if (!hs_request_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_cnt_d = err_cnt_q;
        if ((state_d == ERROR) && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
        // Outputs are decoded from the next state so they change on the same edge as the state.
        aligner_reset_d = ((state_d == HUNT) || (state_d == LOCKED)) ? '0 : '1;
        aligned_d       = (state_d == LOCKED);
        error_d         = (state_d == ERROR);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= IDLE;
            settle_q        <= '0;
            timeout_q       <= '0;
            err_cnt_q       <= '0;
            aligner_reset_q <= '1;
            aligned_q       <= 1'b0;
            error_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            settle_q        <= settle_d;
            timeout_q       <= timeout_d;
            err_cnt_q       <= err_cnt_d;
            aligner_reset_q <= aligner_reset_d;
            aligned_q       <= aligned_d;
            error_q         <= error_d;
        end
    end

    assign aligner_reset_o = aligner_reset_q;
    assign lanes_aligned_o = aligned_q;
    assign align_error_o   = error_q;
    assign error_count_o   = err_cnt_q;

endmodule
